conv_ibuf: RTL

- Input buffer for one convolution layer; sits directly upstream of conv_ctrl.
- Accepts a raster-order pixel stream from the previous layer and keeps a line buffer of the last KERNEL_DIM-1 rows plus KERNEL_DIM pixels.
- On each complete KxK window, requests conv_ctrl to start.
- Serves the window bit-serially: one bit-plane per count, one address-selected slice per cycle, to the CIM row drivers.

---
 rtl/conv_ibuf_if.sv | 35 +++
 rtl/conv_ibuf.sv | 132 +++++++++++++
 2 files changed

// File: rtl/conv_ibuf_if.sv
// Pixel-stream, conv_ctrl handshake and CIM slice bus of conv_ibuf.
// Derived widths are recomputed here, so instantiate with the same parameters as the module.
interface conv_ibuf_if #(
    parameter int DATA_SIZE      = 8,
    parameter int INPUT_CHANNELS = 16,
    parameter int KERNEL_DIM     = 3,
    parameter int XBAR_SIZE      = 128,
    parameter int BUS_WIDTH      = 16
);
    localparam int NUM_ELEM        = INPUT_CHANNELS * KERNEL_DIM * KERNEL_DIM;
    localparam int V_CIM_TILES_OUT = (NUM_ELEM + XBAR_SIZE - 1) / XBAR_SIZE;
    localparam int OUT_W           = BUS_WIDTH * V_CIM_TILES_OUT;
    localparam int NUM_ADDR        = (NUM_ELEM + OUT_W - 1) / OUT_W;
    localparam int ADDR_WIDTH      = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
    localparam int COUNT_WIDTH     = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    logic                                i_valid;
    logic [INPUT_CHANNELS*DATA_SIZE-1:0] i_data;
    logic                                o_ready;
    logic                                o_start;
    logic                                i_ctrl_ready;
    logic [ADDR_WIDTH-1:0]               i_addr;
    logic [COUNT_WIDTH-1:0]              i_count;
    logic [OUT_W-1:0]                    o_data;

    modport master (
        output i_valid, i_data, i_ctrl_ready, i_addr, i_count,
        input  o_ready, o_start, o_data
    );

    modport slave (
        input  i_valid, i_data, i_ctrl_ready, i_addr, i_count,
        output o_ready, o_start, o_data
    );
endinterface

// File: rtl/conv_ibuf.sv
// Convolution input buffer: line buffer of the last K-1 rows plus K pixels, window
// request handshake to conv_ctrl, and bit-serial slice readout of the frozen window.
module conv_ibuf #(
    parameter int DATA_SIZE      = 8,
    parameter int INPUT_CHANNELS = 16,
    parameter int KERNEL_DIM     = 3,
    parameter int IMG_WIDTH      = 8,
    parameter int IMG_HEIGHT     = 8,
    parameter int XBAR_SIZE      = 128,
    parameter int BUS_WIDTH      = 16
) (
    input  logic        clk,
    input  logic        rst,
    conv_ibuf_if.slave  bus
);
    localparam int K               = KERNEL_DIM;
    localparam int NUM_ELEM        = INPUT_CHANNELS * K * K;
    localparam int V_CIM_TILES_OUT = (NUM_ELEM + XBAR_SIZE - 1) / XBAR_SIZE;
    localparam int OUT_W           = BUS_WIDTH * V_CIM_TILES_OUT;
    localparam int PIX_W           = INPUT_CHANNELS * DATA_SIZE;
    localparam int LB_DEPTH        = (K - 1) * IMG_WIDTH + K;
    localparam int COL_W           = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W           = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t           state_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             ready_q;
    logic             start_q;

    logic [PIX_W-1:0]     lb_q [LB_DEPTH];
    logic [DATA_SIZE-1:0] win  [NUM_ELEM];
    logic [OUT_W-1:0]     data_d;

    logic accept;
    logic win_valid;
    logic last_col;
    logic last_row;

    assign accept    = bus.i_valid & ready_q;
    assign last_col  = (col_q == COL_W'(IMG_WIDTH - 1));
    assign last_row  = (row_q == ROW_W'(IMG_HEIGHT - 1));
    assign win_valid = accept && (row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1));

    // Shift register of raw pixels, newest at index 0; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_q[0] <= bus.i_data;
            for (int unsigned i = 1; i < LB_DEPTH; i++) begin
                lb_q[i] <= lb_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            row_q   <= '0;
            col_q   <= '0;
            ready_q <= 1'b1;
            start_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        if (last_col) begin
                            col_q <= '0;
                            row_q <= last_row ? '0 : row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                        if (win_valid) begin
                            state_q <= REQ;
                            ready_q <= 1'b0;
                            start_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (!bus.i_ctrl_ready) begin
                        state_q <= BUSY;
                        start_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (bus.i_ctrl_ready) begin
                        state_q <= FILL;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= FILL;
                    ready_q <= 1'b1;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

    // Window pixel (ky,kx) sits (K-1-ky) rows and (K-1-kx) pixels behind the newest one.
    always_comb begin
        for (int unsigned ky = 0; ky < K; ky++) begin
            for (int unsigned kx = 0; kx < K; kx++) begin
                for (int unsigned c = 0; c < INPUT_CHANNELS; c++) begin
                    win[(ky*K + kx)*INPUT_CHANNELS + c] =
                        lb_q[(K-1-ky)*IMG_WIDTH + (K-1-kx)][c*DATA_SIZE +: DATA_SIZE];
                end
            end
        end
    end

    always_comb begin
        int unsigned base;
        data_d = '0;
        base   = 32'(bus.i_addr) * 32'(OUT_W);
        for (int unsigned j = 0; j < OUT_W; j++) begin
            if ((base + j < NUM_ELEM) && (32'(bus.i_count) < 32'(DATA_SIZE))) begin
                data_d[j] = win[base + j][bus.i_count];
            end
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_start = start_q;
    assign bus.o_data  = data_d;
endmodule
